mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Consumer end of the EX/MEM pipeline register in the 8-bit pipelined processor.
- Accepts the registered EX/MEM outputs (store data, ALU result, memory and writeback controls), performs the data-memory access, and selects the writeback value.
- Owns a memory-mapped output port and registers everything into the MEM/WB register that drives the register file.

Parameters:
- ADDR_W, 8, data-memory address width; depth is 2^ADDR_W bytes.
- IO_ADDR, 8'hFF, address decoded as the I/O port instead of RAM.

Ports:
- clk1  input  1  single pipeline clock, all state updates on its rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk1
- stall  input  1  hold MEM/WB contents; suppress memory/IO writes this cycle
- b_in  input  8  store data (EX/MEM B output)
- alu_in  input  8  ALU result, used as memory address and as non-load writeback value
- memwrite_in  input  1  store request
- memread_in  input  1  load request
- memtoreg_in  input  1  1 = write back load data, 0 = write back alu_in
- regwrite_in  input  1  instruction writes the register file
- rd_in  input  3  destination register index
- io_in  input  8  external input, returned by loads from IO_ADDR
- wb_data  output  8  registered writeback value
- wb_regwrite  output  1  registered register-file write enable
- wb_rd  output  3  registered destination index
- io_out  output  8  registered I/O port value
- io_strobe  output  1  one-cycle pulse when io_out is updated

Behaviour:
- Reset (rst_n=0 at a rising clk1 edge): wb_data=0, wb_regwrite=0, wb_rd=0, io_out=0, io_strobe=0. RAM contents are not cleared. Reset overrides stall and any in-flight store. No write occurs on that edge.
- Address: addr = alu_in[ADDR_W-1:0]. is_io = (alu_in == IO_ADDR).
- RAM read is combinational (asynchronous). Load data is sampled in the same cycle, so the load result appears on wb_data one edge after the instruction presents on the inputs.
- Load data mux: is_io ? io_in : ram[addr]. memread_in=0 gives load data 8'h00.
- Store, on an edge with rst_n=1, stall=0 and memwrite_in=1:
  - is_io=0: ram[addr] <= b_in.
  - is_io=1: io_out <= b_in and io_strobe=1 for the following cycle. The RAM location is untouched.
- io_strobe is 0 in every cycle not immediately following an IO store.
- memread_in and memwrite_in both 1: the store executes. The load returns the pre-store value (read-before-write).
- MEM/WB register, on an edge with rst_n=1 and stall=0:
  - wb_data <= memtoreg_in ? load_data : alu_in.
  - wb_regwrite <= regwrite_in.
  - wb_rd <= rd_in.
- stall=1: wb_data, wb_regwrite, wb_rd and io_out hold. No RAM write. io_strobe=0.
- Back-to-back store then load to the same address: the load in the next cycle returns the new data, because the RAM write completed at the previous edge.
- Address wrap: alu_in bits above ADDR_W are ignored for RAM. The IO decode compares the full 8 bits.
- Latency: 1 clk1 edge from inputs to wb_* outputs. Throughput: one instruction per cycle when stall=0.

Test Plan:
1. Reset: rst_n=0 for 2 edges with all inputs at 1 -> all outputs 0 and io_strobe=0. Then RAM[0x10] written after reset reads back correctly.
2. Store/load: store b_in=8'hA5 at alu_in=8'h10, next cycle load 8'h10 with memtoreg_in=1, regwrite_in=1, rd_in=3 -> one edge later wb_data=8'hA5, wb_regwrite=1, wb_rd=3.
3. ALU passthrough: memtoreg_in=0, alu_in=8'h3C, regwrite_in=1, rd_in=5 -> wb_data=8'h3C next edge. RAM unchanged, verified by a later load.
4. I/O: store 8'h7E to 8'hFF -> io_out=8'h7E with io_strobe=1 for exactly one cycle. Load from 8'hFF with io_in=8'h42 -> wb_data=8'h42.
5. Stall: with wb_data=8'h11, assert stall=1 while presenting a store of 8'h99 to 8'h20 and a new writeback -> wb_* held at old values, no write. A later load of 8'h20 returns the prior contents.
6. Simultaneous read+write: memread_in=memwrite_in=memtoreg_in=1 at 8'h30 holding 8'h01, b_in=8'h02 -> wb_data=8'h01. A subsequent load of 8'h30 returns 8'h02.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM stage of the 8-bit pipeline: data-memory/IO access plus the MEM/WB register.
// RAM reads are combinational; stores and the MEM/WB register update on clk1.
module mem_wb_stage #(
    parameter int         ADDR_W  = 8,
    parameter logic [7:0] IO_ADDR = 8'hFF
) (
    input  logic       clk1,
    input  logic       rst_n,
    input  logic       stall,
    input  logic [7:0] b_in,
    input  logic [7:0] alu_in,
    input  logic       memwrite_in,
    input  logic       memread_in,
    input  logic       memtoreg_in,
    input  logic       regwrite_in,
    input  logic [2:0] rd_in,
    input  logic [7:0] io_in,
    output logic [7:0] wb_data,
    output logic       wb_regwrite,
    output logic [2:0] wb_rd,
    output logic [7:0] io_out,
    output logic       io_strobe
);

    typedef struct packed {
        logic [7:0] data;
        logic       regwrite;
        logic [2:0] rd;
    } wb_t;

    logic [7:0]        ram [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] addr;
    logic              is_io;
    logic              advance;
    logic [7:0]        load_data;
    wb_t               wb_q;

    assign addr    = alu_in[ADDR_W-1:0];
    assign is_io   = (alu_in == IO_ADDR);
    assign advance = rst_n && !stall;

    // Read sees the pre-edge contents, giving read-before-write on combined access.
    always_comb begin
        load_data = 8'h00;
        if (memread_in)
            load_data = is_io ? io_in : ram[addr];
    end

    // RAM has no reset; contents survive rst_n.
    always_ff @(posedge clk1) begin
        if (advance && memwrite_in && !is_io)
            ram[addr] <= b_in;
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            wb_q      <= '0;
            io_out    <= 8'h00;
            io_strobe <= 1'b0;
        end else begin
            io_strobe <= 1'b0;
            if (!stall) begin
                wb_q.data     <= memtoreg_in ? load_data : alu_in;
                wb_q.regwrite <= regwrite_in;
                wb_q.rd       <= rd_in;
                if (memwrite_in && is_io) begin
                    io_out    <= b_in;
                    io_strobe <= 1'b1;
                end
            end
        end
    end

    assign wb_data     = wb_q.data;
    assign wb_regwrite = wb_q.regwrite;
    assign wb_rd       = wb_q.rd;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: inputs change and outputs are sampled on negedge clk1.
module tb_mem_wb_stage;

    logic       clk1 = 1'b0;
    logic       rst_n, stall;
    logic [7:0] b_in, alu_in, io_in;
    logic       memwrite_in, memread_in, memtoreg_in, regwrite_in;
    logic [2:0] rd_in;
    logic [7:0] wb_data, io_out;
    logic       wb_regwrite, io_strobe;
    logic [2:0] wb_rd;

    int total = 0;
    int bad   = 0;

    always #5 clk1 = ~clk1;

    mem_wb_stage #(.ADDR_W(8), .IO_ADDR(8'hFF)) dut (
        .clk1(clk1), .rst_n(rst_n), .stall(stall),
        .b_in(b_in), .alu_in(alu_in),
        .memwrite_in(memwrite_in), .memread_in(memread_in),
        .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in),
        .rd_in(rd_in), .io_in(io_in),
        .wb_data(wb_data), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .io_out(io_out), .io_strobe(io_strobe)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic mw, input logic mr, input logic mt, input logic rw,
                         input logic [2:0] rd, input logic [7:0] alu, input logic [7:0] b);
        memwrite_in = mw; memread_in = mr; memtoreg_in = mt; regwrite_in = rw;
        rd_in = rd; alu_in = alu; b_in = b;
    endtask

    task automatic step();
        @(negedge clk1);
    endtask

    initial begin
        // 1. reset with every input high
        rst_n = 1'b0; stall = 1'b1; io_in = 8'hFF;
        drive(1, 1, 1, 1, 3'h7, 8'hFF, 8'hFF);
        step(); step();
        check("rst wb_data",     wb_data,            8'h00);
        check("rst wb_regwrite", {7'b0, wb_regwrite}, 8'h00);
        check("rst wb_rd",       {5'b0, wb_rd},       8'h00);
        check("rst io_out",      io_out,             8'h00);
        check("rst io_strobe",   {7'b0, io_strobe},  8'h00);

        // 2. store A5 @10, then load it
        rst_n = 1'b1; stall = 1'b0;
        drive(1, 0, 0, 0, 3'h0, 8'h10, 8'hA5);
        step();
        check("store wb_data alu", wb_data,           8'h10);
        check("store no strobe",   {7'b0, io_strobe}, 8'h00);
        drive(0, 1, 1, 1, 3'h3, 8'h10, 8'h00);
        step();
        check("load wb_data",     wb_data,            8'hA5);
        check("load wb_regwrite", {7'b0, wb_regwrite}, 8'h01);
        check("load wb_rd",       {5'b0, wb_rd},       8'h03);

        // 3. ALU passthrough leaves RAM alone
        drive(1, 0, 0, 0, 3'h0, 8'h3C, 8'h5A);
        step();
        drive(0, 0, 0, 1, 3'h5, 8'h3C, 8'hEE);
        step();
        check("pass wb_data", wb_data,       8'h3C);
        check("pass wb_rd",   {5'b0, wb_rd}, 8'h05);
        drive(0, 1, 1, 1, 3'h1, 8'h3C, 8'h00);
        step();
        check("pass ram intact", wb_data, 8'h5A);
        // memread low forces load data to zero
        drive(0, 0, 1, 1, 3'h1, 8'h3C, 8'h00);
        step();
        check("no memread zero", wb_data, 8'h00);

        // 4. IO store and load
        drive(1, 0, 0, 0, 3'h0, 8'hFF, 8'h7E);
        step();
        check("io_out",       io_out,            8'h7E);
        check("io strobe on", {7'b0, io_strobe}, 8'h01);
        drive(0, 0, 0, 0, 3'h0, 8'h00, 8'h00);
        step();
        check("io strobe off", {7'b0, io_strobe}, 8'h00);
        check("io_out hold",   io_out,            8'h7E);
        io_in = 8'h42;
        drive(0, 1, 1, 1, 3'h1, 8'hFF, 8'h00);
        step();
        check("io load", wb_data, 8'h42);

        // 5. stall holds wb_*, blocks RAM and IO writes
        drive(1, 0, 0, 0, 3'h0, 8'h20, 8'h33);
        step();
        drive(0, 0, 0, 1, 3'h2, 8'h11, 8'h00);
        step();
        check("pre-stall wb_data", wb_data, 8'h11);
        stall = 1'b1;
        drive(1, 0, 0, 0, 3'h6, 8'h20, 8'h99);
        step();
        check("stall wb_data",     wb_data,            8'h11);
        check("stall wb_regwrite", {7'b0, wb_regwrite}, 8'h01);
        check("stall wb_rd",       {5'b0, wb_rd},       8'h02);
        drive(1, 0, 0, 0, 3'h6, 8'hFF, 8'h55);
        step();
        check("stall io_out",    io_out,            8'h7E);
        check("stall io_strobe", {7'b0, io_strobe}, 8'h00);
        stall = 1'b0;
        drive(0, 1, 1, 1, 3'h1, 8'h20, 8'h00);
        step();
        check("stall no ram write", wb_data, 8'h33);

        // 6. read+write same cycle returns old value
        drive(1, 0, 0, 0, 3'h0, 8'h30, 8'h01);
        step();
        drive(1, 1, 1, 1, 3'h4, 8'h30, 8'h02);
        step();
        check("rw old value", wb_data,       8'h01);
        check("rw wb_rd",     {5'b0, wb_rd}, 8'h04);
        drive(0, 1, 1, 1, 3'h4, 8'h30, 8'h00);
        step();
        check("rw new value", wb_data, 8'h02);

        // reset blocks an in-flight store and IO write
        rst_n = 1'b0;
        drive(1, 0, 0, 1, 3'h7, 8'h10, 8'hAB);
        step();
        check("rst2 wb_data", wb_data, 8'h00);
        check("rst2 io_out",  io_out,  8'h00);
        rst_n = 1'b1;
        drive(0, 1, 1, 1, 3'h2, 8'h10, 8'h00);
        step();
        check("rst2 ram kept", wb_data, 8'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
